// File: rtl/line_clear.sv
// Playfield line-clear engine: scans rows bottom-up, squeezes out full rows and zero-fills the top.
// Optional scoring is enabled with LINE_CLEAR_SCORE_EN.
module line_clear #(
    parameter int ROWS = 20,
    parameter int COLS = 10,
    parameter int CW   = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    output logic [4:0]           rd_addr,
    input  logic [COLS*CW-1:0]   rd_data,
    output logic                 wr_en,
    output logic [4:0]           wr_addr,
    output logic [COLS*CW-1:0]   wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines,
    output logic [15:0]          score
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EVAL,
        S_FILL,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [4:0]          rp_q;
    logic [4:0]          wp_q;
    logic [4:0]          cnt_q;
    logic [4:0]          fill_q;
    logic [4:0]          rd_addr_q;
    logic                wr_en_q;
    logic [4:0]          wr_addr_q;
    logic [COLS*CW-1:0]  wr_data_q;
    logic                busy_q;
    logic                done_q;
    logic [4:0]          lines_q;
    logic                row_full;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (rd_data[c*CW +: CW] == '0) row_full = 1'b0;
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q;
    logic [15:0] score_d;
    logic [15:0] pts;
    logic [16:0] sum;

    always_comb begin
        case (cnt_q)
            5'd0:    pts = 16'd0;
            5'd1:    pts = 16'd40;
            5'd2:    pts = 16'd100;
            5'd3:    pts = 16'd300;
            default: pts = 16'd1200;
        endcase
        sum     = {1'b0, score_q} + {1'b0, pts};
        score_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            score_q <= '0;
        end else if (state_q == S_DONE) begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = 16'd0;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            rp_q      <= '0;
            wp_q      <= '0;
            cnt_q     <= '0;
            fill_q    <= '0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lines_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rp_q      <= LAST_ROW;
                        wp_q      <= LAST_ROW;
                        cnt_q     <= '0;
                        fill_q    <= '0;
                        rd_addr_q <= LAST_ROW;
                        busy_q    <= 1'b1;
                        state_q   <= S_READ;
                    end
                end
                // rd_addr already holds rp here; the grid registers the row this cycle.
                S_READ: begin
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    if (row_full) begin
                        cnt_q <= cnt_q + 5'd1;
                    end else begin
                        if (wp_q != rp_q) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= wp_q;
                            wr_data_q <= rd_data;
                        end
                        wp_q <= wp_q - 5'd1;
                    end
                    if (rp_q == 5'd0) begin
                        state_q <= S_FILL;
                    end else begin
                        rp_q      <= rp_q - 5'd1;
                        rd_addr_q <= rp_q - 5'd1;
                        state_q   <= S_READ;
                    end
                end
                S_FILL: begin
                    if (cnt_q > fill_q) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wp_q;
                        wr_data_q <= '0;
                        wp_q      <= wp_q - 5'd1;
                        fill_q    <= fill_q + 5'd1;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    lines_q <= cnt_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign lines   = lines_q;

endmodule

// File: tb/tb_line_clear.sv
// Directed bench for line_clear: a registered-read grid model around the DUT, per-scenario tasks.
module tb_line_clear;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int CW   = 3;
    localparam int W    = COLS * CW;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [4:0]    rd_addr;
    logic [W-1:0]  rd_data;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          done;
    logic [4:0]    lines;
    logic [15:0]   score;

    logic [W-1:0]  mem [ROWS];
    logic [W-1:0]  exp_g [ROWS];
    logic [W-1:0]  full_row;
    logic [15:0]   exp_score;

    int total = 0;
    int bad   = 0;

    line_clear #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .lines   (lines),
        .score   (score)
    );

    always #5 clk = ~clk;

    // grid memory: registered read, synchronous write
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    function automatic logic [W-1:0] nf(input int r);
        return W'(r + 1);
    endfunction

    function automatic logic [15:0] pts(input int n);
`ifdef LINE_CLEAR_SCORE_EN
        case (n)
            0: return 16'd0;
            1: return 16'd40;
            2: return 16'd100;
            3: return 16'd300;
            default: return 16'd1200;
        endcase
`else
        return 16'd0;
`endif
    endfunction

    task automatic run_scan(input int pulse_at, output int lat, output int nwr, output int ndone);
        int n;
        lat = 0; nwr = 0; ndone = 0; n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n < 200 && (lat == 0 || n < lat + 6)) begin
            @(posedge clk); #1;
            n++;
            start = (n == pulse_at) ? 1'b1 : 1'b0;
            if (wr_en) nwr++;
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
            end
        end
        start = 1'b0;
    endtask

    task automatic load_pattern(input int kind);
        for (int r = 0; r < ROWS; r++) mem[r] = nf(r);
        case (kind)
            2: begin
                mem[19] = full_row;
                mem[18] = W'(2) << 12;
            end
            3: for (int r = 16; r < 20; r++) mem[r] = full_row;
            4: begin
                mem[17] = full_row;
                mem[19] = full_row;
            end
            default: for (int r = 0; r < ROWS; r++) mem[r] = '0;
        endcase
    endtask

    task automatic test_reset;
        n_rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rd_addr !== 5'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_addr !== 5'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        total++; if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        total++; if (lines !== 5'd0 || score !== 16'd0) begin bad++; $display("FAIL reset_lines_score got=%0d/%0d exp=0/0", lines, score); end
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_scan(input string name, input int lat, input int nwr, input int ndone,
                              input int e_lines, input int e_lat, input int e_nwr);
        int nbad;
        nbad = 0;
        total++; if (lat == 0) begin bad++; $display("FAIL %s_timeout no done within budget", name); end
        total++; if (lat != e_lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, e_lat); end
        total++; if (ndone != 1) begin bad++; $display("FAIL %s_done_count got=%0d exp=1", name, ndone); end
        total++; if (lines !== 5'(e_lines)) begin bad++; $display("FAIL %s_lines got=%0d exp=%0d", name, lines, e_lines); end
        total++; if (nwr != e_nwr) begin bad++; $display("FAIL %s_writes got=%0d exp=%0d", name, nwr, e_nwr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_after got=%b exp=0", name, busy); end
        exp_score = (exp_score + pts(e_lines) > 16'hFFFF) ? 16'hFFFF : exp_score + pts(e_lines);
        total++; if (score !== exp_score) begin bad++; $display("FAIL %s_score got=%0d exp=%0d", name, score, exp_score); end
        for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_g[r]) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL %s_grid rows_wrong=%0d exp=0", name, nbad); end
    endtask

    task automatic test_empty;
        int lat, nwr, nd;
        load_pattern(0);
        for (int r = 0; r < ROWS; r++) exp_g[r] = '0;
        run_scan(-1, lat, nwr, nd);
        check_scan("empty", lat, nwr, nd, 0, 42, 0);
    endtask

    task automatic test_one_line;
        int lat, nwr, nd;
        load_pattern(2);
        for (int r = 1; r < ROWS; r++) exp_g[r] = mem[r-1];
        exp_g[0] = '0;
        run_scan(-1, lat, nwr, nd);
        check_scan("one_line", lat, nwr, nd, 1, 43, 20);
    endtask

    task automatic test_four_lines;
        int lat, nwr, nd;
        load_pattern(3);
        for (int r = 4; r < ROWS; r++) exp_g[r] = nf(r - 4);
        for (int r = 0; r < 4; r++) exp_g[r] = '0;
        run_scan(-1, lat, nwr, nd);
        check_scan("four_lines", lat, nwr, nd, 4, 46, 20);
    endtask

    task automatic test_split_lines;
        int lat, nwr, nd;
        load_pattern(4);
        exp_g[19] = nf(18);
        exp_g[18] = nf(16);
        for (int r = 2; r < 18; r++) exp_g[r] = nf(r - 2);
        exp_g[0] = '0; exp_g[1] = '0;
        run_scan(-1, lat, nwr, nd);
        // row 18 moves, rows 16..0 move, plus two zero rows
        check_scan("split_lines", lat, nwr, nd, 2, 44, 20);
    endtask

    task automatic test_start_while_busy;
        int lat, nwr, nd;
        load_pattern(2);
        for (int r = 1; r < ROWS; r++) exp_g[r] = mem[r-1];
        exp_g[0] = '0;
        run_scan(10, lat, nwr, nd);
        check_scan("restart_ignored", lat, nwr, nd, 1, 43, 20);
    endtask

    task automatic test_reset_mid_scan;
        int lat, nwr, nd;
        load_pattern(3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy_before got=%b exp=1", busy); end
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL midreset_wr_en got=%b exp=0", wr_en); end
        total++; if (lines !== 5'd0) begin bad++; $display("FAIL midreset_lines got=%0d exp=0", lines); end
        total++; if (score !== 16'd0) begin bad++; $display("FAIL midreset_score got=%0d exp=0", score); end
        exp_score = 16'd0;
        @(posedge clk); #1;
        load_pattern(3);
        for (int r = 4; r < ROWS; r++) exp_g[r] = nf(r - 4);
        for (int r = 0; r < 4; r++) exp_g[r] = '0;
        run_scan(-1, lat, nwr, nd);
        check_scan("after_reset", lat, nwr, nd, 4, 46, 20);
    endtask

    initial begin
        full_row  = {COLS{3'd1}};
        exp_score = 16'd0;
        n_rst     = 1'b0;
        start     = 1'b0;
        for (int r = 0; r < ROWS; r++) mem[r] = '0;
        test_reset;
        test_empty;
        test_one_line;
        test_four_lines;
        test_split_lines;
        test_start_while_busy;
        test_reset_mid_scan;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
